// File: rtl/fp_normalize_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack_if
// Description : Operand/result valid-ready bundle for fp_normalize_pack.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_normalize_pack_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sign;
    logic [EXP_W-1:0]          in_exp;
    logic [MANT_W:0]           in_mant;
    logic [2:0]                in_grs;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W+MANT_W-1:0]   out_result;
    logic                      out_overflow;
    logic                      out_underflow;
    logic                      out_zero;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_zero
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack
// Description : FP add/sub post-stage: iterative normalize, RNE round, pack.
//               Optional sticky status register under FP_STATUS_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_pack #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fp_normalize_pack_if.slave   bus
`ifdef FP_STATUS_STICKY_EN
    ,
    input  logic                 status_clear,
    output logic [2:0]           status_flags
`endif
);
    localparam int XW = EXP_W + 1;
    localparam int FW = MANT_W - 1;
    localparam int RW = EXP_W + MANT_W;
    localparam logic [XW-1:0] c_exp_max = XW'((1 << EXP_W) - 1);
    localparam logic [XW-1:0] c_exp_one = XW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

    state_t            r_state, w_state;
    logic              r_sign, w_sign;
    logic [XW-1:0]     r_exp, w_exp;
    logic [MANT_W:0]   r_mant, w_mant;
    logic              r_g, r_r, r_s, w_g, w_r, w_s;
    logic [RW-1:0]     r_result, w_result;
    logic              r_ovf, r_unf, r_zero, w_ovf, w_unf, w_zero;
`ifdef FP_STATUS_STICKY_EN
    logic              r_inexact, w_inexact;
`endif

    logic              w_round_up;
    logic [MANT_W:0]   w_sum, w_mant_rnd;
    logic [XW-1:0]     w_exp_rnd;

    assign w_round_up = r_g & (r_r | r_s | r_mant[0]);
    assign w_sum      = {1'b0, r_mant[MANT_W-1:0]} + {{MANT_W{1'b0}}, w_round_up};
    assign w_mant_rnd = w_sum[MANT_W] ? (w_sum >> 1) : w_sum;
    assign w_exp_rnd  = r_exp + {{EXP_W{1'b0}}, w_sum[MANT_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_g      <= 1'b0;
            r_r      <= 1'b0;
            r_s      <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_zero   <= 1'b0;
`ifdef FP_STATUS_STICKY_EN
            r_inexact <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_sign   <= w_sign;
            r_exp    <= w_exp;
            r_mant   <= w_mant;
            r_g      <= w_g;
            r_r      <= w_r;
            r_s      <= w_s;
            r_result <= w_result;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
            r_zero   <= w_zero;
`ifdef FP_STATUS_STICKY_EN
            r_inexact <= w_inexact;
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_sign   = r_sign;
        w_exp    = r_exp;
        w_mant   = r_mant;
        w_g      = r_g;
        w_r      = r_r;
        w_s      = r_s;
        w_result = r_result;
        w_ovf    = r_ovf;
        w_unf    = r_unf;
        w_zero   = r_zero;
`ifdef FP_STATUS_STICKY_EN
        w_inexact = r_inexact;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_sign = bus.in_sign;
                    w_exp  = {1'b0, bus.in_exp};
                    w_mant = bus.in_mant;
                    {w_g, w_r, w_s} = bus.in_grs;
                    if (bus.in_mant == '0 && bus.in_grs == 3'b000) begin
                        w_result = {bus.in_sign, {(RW-1){1'b0}}};
                        w_zero   = 1'b1;
                        w_state  = S_DONE;
                    end else begin
                        w_state  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_mant[MANT_W]) begin
                    w_mant  = r_mant >> 1;
                    w_g     = r_mant[0];
                    w_r     = r_g;
                    w_s     = r_r | r_s;
                    w_exp   = r_exp + c_exp_one;
                    w_state = S_ROUND;
                end else if (r_mant[MANT_W-1]) begin
                    w_state = S_ROUND;
                end else if (r_exp <= c_exp_one) begin
                    // No denormal output: anything below the normal range flushes.
                    w_result = {r_sign, {(RW-1){1'b0}}};
                    w_unf    = 1'b1;
`ifdef FP_STATUS_STICKY_EN
                    w_inexact = (|r_mant) | r_g | r_r | r_s;
`endif
                    w_state  = S_DONE;
                end else begin
                    w_mant = {1'b0, r_mant[MANT_W-2:0], r_g};
                    w_g    = r_r;
                    w_r    = 1'b0;
                    w_exp  = r_exp - c_exp_one;
                end
            end
            S_ROUND: begin
                w_mant = w_mant_rnd;
                w_exp  = w_exp_rnd;
`ifdef FP_STATUS_STICKY_EN
                w_inexact = r_g | r_r | r_s;
`endif
                if (w_exp_rnd >= c_exp_max) begin
                    w_result = {r_sign, {EXP_W{1'b1}}, {FW{1'b0}}};
                    w_ovf    = 1'b1;
                end else begin
                    w_result = {r_sign, w_exp_rnd[EXP_W-1:0], w_mant_rnd[FW-1:0]};
                end
                w_state = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_ovf   = 1'b0;
                    w_unf   = 1'b0;
                    w_zero  = 1'b0;
`ifdef FP_STATUS_STICKY_EN
                    w_inexact = 1'b0;
`endif
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.in_ready      = (r_state == S_IDLE) && !reset;
    assign bus.out_valid     = (r_state == S_DONE);
    assign bus.out_result    = r_result;
    assign bus.out_overflow  = r_ovf;
    assign bus.out_underflow = r_unf;
    assign bus.out_zero      = r_zero;

`ifdef FP_STATUS_STICKY_EN
    logic [2:0] r_status;

    // Clear wins over a handshake landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || status_clear) begin
            r_status <= 3'b000;
        end else if (bus.out_valid && bus.out_ready) begin
            r_status <= r_status | {r_ovf, r_unf, r_inexact};
        end
    end

    assign status_flags = r_status;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_pack
// Description : Scoreboard bench for fp_normalize_pack with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_pack;
    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;
`ifdef FP_STATUS_STICKY_EN
    logic       status_clear;
    logic [2:0] status_flags;
`endif

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   presented = 1'b0;

    fp_normalize_pack_if bus ();

    fp_normalize_pack dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef FP_STATUS_STICKY_EN
        ,
        .status_clear (status_clear),
        .status_flags (status_flags)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m,
                         input logic [2:0] grs, input logic [31:0] res,
                         input logic [2:0] fl, input int lat, input bit expect_out);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_grs   = grs;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (expect_out) begin
            x.res  = res;
            x.ovf  = fl[2];
            x.unf  = fl[1];
            x.zero = fl[0];
            x.lat  = lat;
            x.acc  = cycle;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: pop on first presentation, then check the result holds until taken.
    always @(negedge clk) begin
        if (reset) begin
            presented = 1'b0;
        end else if (bus.out_valid) begin
            if (!presented) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", bus.out_result, 32'hxxxxxxxx);
                end else begin
                    cur = sb.pop_front();
                    chk("result", bus.out_result, cur.res);
                    chk("flags", {29'd0, bus.out_overflow, bus.out_underflow, bus.out_zero},
                        {29'd0, cur.ovf, cur.unf, cur.zero});
                    chk("latency", cycle - cur.acc + 1, cur.lat);
                end
                presented = 1'b1;
            end else begin
                chk("hold", {bus.out_result, bus.in_ready}, {cur.res, 1'b0});
            end
            if (bus.out_ready) presented = 1'b0;
        end else begin
            chk("idle_flags", {29'd0, bus.out_overflow, bus.out_underflow, bus.out_zero}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_grs    = '0;
        bus.out_ready = 1'b1;
`ifdef FP_STATUS_STICKY_EN
        status_clear  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.out_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        issue(1'b0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 3'b000, 3, 1'b1);
        issue(1'b0, 8'd127, 25'h1800000, 3'b000, 32'h40400000, 3'b000, 3, 1'b1);
        issue(1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 3'b000, 26, 1'b1);
        issue(1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b000, 3, 1'b1);
        issue(1'b0, 8'd127, 25'h0400000, 3'b110, 32'h3F000002, 3'b000, 4, 1'b1);
        drain();
`ifdef FP_STATUS_STICKY_EN
        @(negedge clk);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
        chk("status_cleared", {29'd0, status_flags}, 32'd0);
`endif
        issue(1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 3'b000, 3, 1'b1);
        drain();
`ifdef FP_STATUS_STICKY_EN
        @(negedge clk);
        chk("status_inexact", {29'd0, status_flags}, 32'd1);
`endif
        issue(1'b1, 8'd254, 25'h1000000, 3'b000, 32'hFF800000, 3'b100, 3, 1'b1);
        issue(1'b0, 8'd5,   25'h0000001, 3'b000, 32'h00000000, 3'b010, 6, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        issue(1'b1, 8'd40, 25'h0000000, 3'b000, 32'h80000000, 3'b001, 1, 1'b1);
        repeat (6) @(negedge clk);
        bus.out_ready = 1'b1;
        drain();

        issue(1'b0, 8'd127, 25'h0000001, 3'b000, 32'h0, 3'b000, 0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("abort_no_output", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("resume_in_ready", {31'd0, bus.in_ready}, 32'd1);
        issue(1'b0, 8'd127, 25'h1800000, 3'b000, 32'h40400000, 3'b000, 3, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
